// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline-control blocks: mult/div timer state
// encoding, the hard-wired zero register index and a saturating increment.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline (master) supplies
// the D/E stage decode information; the controller (slave) returns the
// stall/bubble controls and the mult/div status.
interface pipe_hazard_ctrl_if;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic       D_uses_md;
    logic [4:0] E_dst;
    logic       E_is_load;
    logic       E_mispredict;
    logic       E_md_start;
    logic       E_md_is_div;
    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       md_busy;
    logic       md_done;

    modport master (
        output D_rs, D_rt, D_uses_md, E_dst, E_is_load, E_mispredict, E_md_start, E_md_is_div,
        input  F_stall, D_stall, D_bubble, E_bubble, md_busy, md_done
    );

    modport slave (
        input  D_rs, D_rt, D_uses_md, E_dst, E_is_load, E_mispredict, E_md_start, E_md_is_div,
        output F_stall, D_stall, D_bubble, E_bubble, md_busy, md_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// Mult/div busy timer: a down-counter loaded with latency-1 on an accepted
// start, with busy/done registered so they are clean for the hazard logic.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   MD_IDLE | no operation in flight; a start loads the counter
//   MD_BUSY | operation in flight; done is high while the count is 0
module pipe_hazard_ctrl_md_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    md_state_e  state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] latency;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next-state and next-output computation; a start while busy is dropped.
    always_comb begin
        latency = is_div ? 8'(DIV_CYCLES) : 8'(MUL_CYCLES);
        state_d = state_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    count_d = latency - 8'd1;
                    busy_d  = 1'b1;
                    done_d  = (count_d == 8'd0);
                end
            end
            MD_BUSY: begin
                if (count_q == 8'd0) begin
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    count_d = count_q - 8'd1;
                    done_d  = (count_d == 8'd0);
                end
            end
            default: begin
                state_d = MD_IDLE;
                count_d = 8'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Timer state and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and stall/bubble priority for the 5-stage core.
// Optional statistics counters are built when PIPE_HAZARD_CTRL_STATS_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    ,
    output logic [31:0]        stat_stall_cnt,
    output logic [31:0]        stat_flush_cnt,
    output logic [31:0]        stat_md_cnt
`endif
);

    logic md_busy;
    logic md_done;
    logic load_use;
    logic md_hazard;
    logic f_stall, d_stall, d_bubble, e_bubble;

    pipe_hazard_ctrl_md_timer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .start (hz.E_md_start),
        .is_div(hz.E_md_is_div),
        .busy  (md_busy),
        .done  (md_done)
    );

    // Hazard detection and priority; the md hazard releases in the done cycle
    // so the dependent instruction leaves D on the following edge.
    always_comb begin
        load_use  = hz.E_is_load && (hz.E_dst != REG_ZERO) &&
                    ((hz.E_dst == hz.D_rs) || (hz.E_dst == hz.D_rt));
        md_hazard = hz.D_uses_md && ((md_busy && !md_done) || hz.E_md_start);
        f_stall   = 1'b0;
        d_stall   = 1'b0;
        d_bubble  = 1'b0;
        e_bubble  = 1'b0;
        if (!rst) begin
            if (hz.E_mispredict) begin
                d_bubble = 1'b1;
                e_bubble = 1'b1;
            end else if (load_use || md_hazard) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
            end
        end
    end

    assign hz.F_stall  = f_stall;
    assign hz.D_stall  = d_stall;
    assign hz.D_bubble = d_bubble;
    assign hz.E_bubble = e_bubble;
    assign hz.md_busy  = md_busy;
    assign hz.md_done  = md_done;

`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] md_cnt_q,    md_cnt_d;

    // Saturating event counters; a start is accepted only while the timer is idle.
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, f_stall);
        flush_cnt_d = sat_inc(flush_cnt_q, hz.E_mispredict);
        md_cnt_d    = sat_inc(md_cnt_q, hz.E_md_start && !md_busy);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            md_cnt_q    <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_flush_cnt = flush_cnt_q;
    assign stat_md_cnt    = md_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MUL=5, DIV=10).
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [31:0] s_stall, s_flush, s_md;
`endif

    pipe_hazard_ctrl #(
        .MUL_CYCLES(MUL_LAT),
        .DIV_CYCLES(DIV_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
`ifdef PIPE_HAZARD_CTRL_STATS_EN
        ,
        .stat_stall_cnt(s_stall),
        .stat_flush_cnt(s_flush),
        .stat_md_cnt   (s_md)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining busy cycles of the mult/div operation in flight.
    int md_left;
    always @(posedge clk or posedge rst) begin
        if (rst)                 md_left = 0;
        else if (md_left > 0)    md_left = md_left - 1;
        else if (hz.E_md_start)  md_left = hz.E_md_is_div ? DIV_LAT : MUL_LAT;
    end

    // Expected {F_stall, D_stall, D_bubble, E_bubble, md_busy, md_done}.
    function automatic logic [5:0] model_out();
        bit busy, done, lu, mh;
        if (rst) return 6'b0;
        busy = (md_left > 0);
        done = (md_left == 1);
        lu = hz.E_is_load && hz.E_dst != 0 && (hz.E_dst == hz.D_rs || hz.E_dst == hz.D_rt);
        mh = hz.D_uses_md && ((busy && !done) || hz.E_md_start);
        if (hz.E_mispredict)  return {4'b0011, busy, done};
        else if (lu || mh)    return {4'b1101, busy, done};
        else                  return {4'b0000, busy, done};
    endfunction

    function automatic logic [5:0] dut_out();
        return {hz.F_stall, hz.D_stall, hz.D_bubble, hz.E_bubble, hz.md_busy, hz.md_done};
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cycle_outputs", 32'(dut_out()), 32'(model_out()));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.D_rs = 5'd0; hz.D_rt = 5'd0; hz.D_uses_md = 1'b0;
        hz.E_dst = 5'd0; hz.E_is_load = 1'b0; hz.E_mispredict = 1'b0;
        hz.E_md_start = 1'b0; hz.E_md_is_div = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_at, stall_cnt, done_cnt;
        rst = 1'b1;
        clear_inputs();
        tick();
        check("reset_outputs", 32'(dut_out()), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Load-use on rs, on rt, and suppressed for register 0.
        hz.E_is_load = 1'b1; hz.E_dst = 5'd8; hz.D_rs = 5'd8; hz.D_rt = 5'd3;
        #1 check("load_use_rs", 32'(dut_out()), 32'b110100);
        hz.D_rs = 5'd2; hz.D_rt = 5'd8;
        #1 check("load_use_rt", 32'(dut_out()), 32'b110100);
        hz.E_dst = 5'd0; hz.D_rs = 5'd0; hz.D_rt = 5'd0;
        #1 check("load_use_r0", 32'(dut_out()), 32'b000000);
        hz.E_is_load = 1'b0; hz.E_dst = 5'd8; hz.D_rs = 5'd8;
        #1 check("no_load_no_stall", 32'(dut_out()), 32'b000000);
        tick();

        // Mispredict outranks load-use.
        clear_inputs();
        hz.E_mispredict = 1'b1; hz.E_is_load = 1'b1; hz.E_dst = 5'd9; hz.D_rt = 5'd9;
        #1 check("mispredict_prio", 32'(dut_out()), 32'b001100);
        tick();
        clear_inputs();
        tick();

        // Multiply with a dependent instruction in D.
        hz.E_md_start = 1'b1; hz.D_uses_md = 1'b1;
        #1 check("mult_start_stall", 32'(hz.F_stall), 32'd1);
        stall_cnt = hz.F_stall ? 1 : 0;
        tick();
        hz.E_md_start = 1'b0;
        busy_cnt = 0; done_at = 0; done_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (hz.md_busy) busy_cnt++;
            if (hz.md_done) begin done_at = i; done_cnt++; end
            if (hz.F_stall) stall_cnt++;
            tick();
        end
        check("mult_busy_len", 32'(busy_cnt), 32'd5);
        check("mult_done_pos", 32'(done_at), 32'd5);
        check("mult_done_once", 32'(done_cnt), 32'd1);
        check("mult_stall_len", 32'(stall_cnt), 32'd5);
        clear_inputs();
        tick();

        // Divide with dependent in D; a stray start mid-operation is ignored.
        hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b1; hz.D_uses_md = 1'b1;
        #1 check("div_start_stall", 32'(dut_out()), 32'b110100);
        tick();
        hz.E_md_start = 1'b0;
        busy_cnt = 0; stall_cnt = 0; done_at = 0;
        for (int i = 1; i <= 14; i++) begin
            hz.E_md_start = (i == 3);
            #1;
            if (hz.md_busy) busy_cnt++;
            if (hz.md_busy && hz.F_stall) stall_cnt++;
            if (hz.md_done) done_at = i;
            tick();
        end
        check("div_busy_len", 32'(busy_cnt), 32'd10);
        check("div_done_pos", 32'(done_at), 32'd10);
        check("div_stall_len", 32'(stall_cnt), 32'd9);
        clear_inputs();
        tick();

        // Reset in the third busy cycle of a divide.
        hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b1;
        tick();
        hz.E_md_start = 1'b0;
        tick();
        tick();
        hz.E_is_load = 1'b1; hz.E_dst = 5'd8; hz.D_rs = 5'd8;
        #1 check("pre_reset_busy", 32'(dut_out()), 32'b110110);
        rst = 1'b1;
        #1 check("async_reset_outputs", 32'(dut_out()), 32'd0);
        tick();
        rst = 1'b0;
        clear_inputs();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (hz.md_busy) busy_cnt++;
            if (hz.md_done) done_cnt++;
            tick();
        end
        check("post_reset_no_busy", 32'(busy_cnt), 32'd0);
        check("post_reset_no_done", 32'(done_cnt), 32'd0);

`ifdef PIPE_HAZARD_CTRL_STATS_EN
        // Two load-use stalls, one mispredict, one mult with dependent.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("stats_reset", 32'(s_stall | s_flush | s_md), 32'd0);
        for (int k = 0; k < 2; k++) begin
            hz.E_is_load = 1'b1; hz.E_dst = 5'd4; hz.D_rt = 5'd4;
            tick();
            clear_inputs();
            tick();
        end
        hz.E_mispredict = 1'b1;
        tick();
        clear_inputs();
        tick();
        hz.E_md_start = 1'b1; hz.D_uses_md = 1'b1;
        tick();
        hz.E_md_start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        clear_inputs();
        tick();
        check("stat_stall_cnt", s_stall, 32'd7);
        check("stat_flush_cnt", s_flush, 32'd1);
        check("stat_md_cnt", s_md, 32'd1);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
